// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store sequencer: access sizes, memory op codes
// and the sequencer state machine.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [2:0] DM_WR  = 3'b000;
    localparam logic [2:0] DM_ADD = 3'b001;
    localparam logic [2:0] DM_SUB = 3'b010;
    localparam logic [2:0] DM_AND = 3'b011;
    localparam logic [2:0] DM_OR  = 3'b100;
    localparam logic [2:0] DM_XOR = 3'b101;
    localparam logic [2:0] DM_SHL = 3'b110;
    localparam logic [2:0] DM_SHR = 3'b111;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SETUP,
        PULSE,
        RESP
    } mau_state_e;

    // Size/alignment legality of a request, independent of the address range.
    function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] lane,
                                       input logic amo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        if (amo && (size != SZ_WORD)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: extracts and extends sub-word load data, and
// merges sub-word store data into the word read back from memory.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [15:0] wdata,
    output logic [31:0] load_val,
    output logic [31:0] merged
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = word;
        case (size)
            SZ_BYTE: load_val = {{24{~uns & byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = {{16{~uns & half_sel[15]}}, half_sel};
            default: load_val = word;
        endcase
    end

    // Each byte lane picks the store data or keeps the old memory byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic sel;
            assign sel = ((size == SZ_BYTE) && (lane == 2'(gi))) ||
                         ((size == SZ_HALF) && (lane[1] == 1'(gi / 2)));
            assign merged[8*gi +: 8] = !sel ? word[8*gi +: 8] :
                                       (size == SZ_HALF) ? wdata[8*(gi % 2) +: 8] :
                                                           wdata[7:0];
        end
    endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store/AMO sequencer in front of a word-organised data memory with an
// edge-triggered write strobe. Every output except req_ready is a flop.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic              req_amo,
    input  logic [2:0]        req_amo_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              DMWr,
    output logic [2:0]        DmControl,
    output logic [31:0]       Address,
    output logic [31:0]       DataWr,
    input  logic [31:0]       DataRd
);

    mau_state_e  state_reg, state_next;
    logic        we_reg, we_next;
    logic        amo_reg, amo_next;
    logic [2:0]  amo_op_reg, amo_op_next;
    logic [1:0]  size_reg, size_next;
    logic        uns_reg, uns_next;
    logic [1:0]  lane_reg, lane_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] rd_q_reg, rd_q_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;
    logic        dmwr_reg, dmwr_next;
    logic [2:0]  dmctl_reg, dmctl_next;
    logic [31:0] address_reg, address_next;
    logic [31:0] datawr_reg, datawr_next;

    logic [ADDR_W-1:0] req_widx;
    logic              req_bad;
    logic [31:0]       load_val;
    logic [31:0]       merged;

    assign req_widx = req_addr >> 2;
    assign req_bad  = bad_shape(req_size, req_addr[1:0], req_amo) ||
                      (req_widx >= ADDR_W'(MEM_WORDS));

    mem_lane_align u_align (
        .word     (DataRd),
        .lane     (lane_reg),
        .size     (size_reg),
        .uns      (uns_reg),
        .wdata    (wdata_reg[15:0]),
        .load_val (load_val),
        .merged   (merged)
    );

    // Registered outputs are computed for the state being entered, so each
    // output value is already stable for the whole cycle of its state.
    always_comb begin
        state_next     = state_reg;
        we_next        = we_reg;
        amo_next       = amo_reg;
        amo_op_next    = amo_op_reg;
        size_next      = size_reg;
        uns_next       = uns_reg;
        lane_next      = lane_reg;
        wdata_next     = wdata_reg;
        rd_q_next      = rd_q_reg;
        rsp_valid_next = 1'b0;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = 1'b0;
        dmwr_next      = 1'b0;
        dmctl_next     = dmctl_reg;
        address_next   = address_reg;
        datawr_next    = datawr_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    we_next      = req_we | req_amo;
                    amo_next     = req_amo;
                    amo_op_next  = req_amo_op;
                    size_next    = req_size;
                    uns_next     = req_unsigned;
                    lane_next    = req_addr[1:0];
                    wdata_next   = req_wdata;
                    address_next = 32'(req_widx);
                    if (req_bad) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                        rsp_rdata_next = 32'd0;
                    end else if ((req_we || req_amo) && !req_amo && (req_size == SZ_WORD)) begin
                        // Full-word store needs no read-back.
                        state_next  = SETUP;
                        datawr_next = req_wdata;
                        dmctl_next  = DM_WR;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                rd_q_next = DataRd;
                if (amo_reg) begin
                    state_next  = SETUP;
                    datawr_next = wdata_reg;
                    dmctl_next  = amo_op_reg;
                end else if (!we_reg) begin
                    state_next     = RESP;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = load_val;
                end else begin
                    state_next  = SETUP;
                    datawr_next = merged;
                    dmctl_next  = DM_WR;
                end
            end
            SETUP: begin
                state_next = PULSE;
                dmwr_next  = 1'b1;
            end
            PULSE: begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_rdata_next = amo_reg ? rd_q_reg : 32'd0;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            we_reg        <= 1'b0;
            amo_reg       <= 1'b0;
            amo_op_reg    <= 3'd0;
            size_reg      <= 2'd0;
            uns_reg       <= 1'b0;
            lane_reg      <= 2'd0;
            wdata_reg     <= 32'd0;
            rd_q_reg      <= 32'd0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'd0;
            rsp_err_reg   <= 1'b0;
            dmwr_reg      <= 1'b0;
            dmctl_reg     <= 3'd0;
            address_reg   <= 32'd0;
            datawr_reg    <= 32'd0;
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            amo_reg       <= amo_next;
            amo_op_reg    <= amo_op_next;
            size_reg      <= size_next;
            uns_reg       <= uns_next;
            lane_reg      <= lane_next;
            wdata_reg     <= wdata_next;
            rd_q_reg      <= rd_q_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
            dmwr_reg      <= dmwr_next;
            dmctl_reg     <= dmctl_next;
            address_reg   <= address_next;
            datawr_reg    <= datawr_next;
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;
    assign DMWr      = dmwr_reg;
    assign DmControl = dmctl_reg;
    assign Address   = address_reg;
    assign DataWr    = datawr_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a behavioural memory that commits on the
// DMWr rising edge, plus response and write-pulse scoreboards with cycle stamps.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned, req_amo;
    logic [1:0]  req_size;
    logic [2:0]  req_amo_op;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err, DMWr;
    logic [31:0] rsp_rdata, Address, DataWr, DataRd;
    logic [2:0]  DmControl;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(1024), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_amo(req_amo),
        .req_amo_op(req_amo_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .DMWr(DMWr), .DmControl(DmControl), .Address(Address),
        .DataWr(DataWr), .DataRd(DataRd)
    );

    logic [31:0] mem [0:1023];
    assign DataRd = mem[Address[9:0]];

    always @(posedge DMWr) begin
        case (DmControl)
            DM_WR:   mem[Address[9:0]] = DataWr;
            DM_ADD:  mem[Address[9:0]] = mem[Address[9:0]] + DataWr;
            DM_SUB:  mem[Address[9:0]] = mem[Address[9:0]] - DataWr;
            DM_AND:  mem[Address[9:0]] = mem[Address[9:0]] & DataWr;
            DM_OR:   mem[Address[9:0]] = mem[Address[9:0]] | DataWr;
            DM_XOR:  mem[Address[9:0]] = mem[Address[9:0]] ^ DataWr;
            DM_SHL:  mem[Address[9:0]] = mem[Address[9:0]] << DataWr[4:0];
            default: mem[Address[9:0]] = mem[Address[9:0]] >> DataWr[4:0];
        endcase
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          edge_no;
    } rsp_t;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  ctl;
        int          edge_no;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    rsp_t r_cur;
    wr_t  w_cur;
    int   edge_cnt = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Response and write-strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rsp_valid) begin
            chk("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
            if (rsp_q.size() != 0) begin
                r_cur = rsp_q.pop_front();
                chk("rsp_rdata", rsp_rdata, r_cur.rdata);
                chk("rsp_err", 32'(rsp_err), 32'(r_cur.err));
                chk("rsp_cycle", 32'(edge_cnt), 32'(r_cur.edge_no));
            end
        end
        if (DMWr) begin
            chk("dmwr_expected", 32'(wr_q.size() != 0), 32'd1);
            if (wr_q.size() != 0) begin
                w_cur = wr_q.pop_front();
                chk("wr_address", Address, w_cur.addr);
                chk("wr_datawr", DataWr, w_cur.data);
                chk("wr_dmcontrol", 32'(DmControl), 32'(w_cur.ctl));
                chk("wr_cycle", 32'(edge_cnt), 32'(w_cur.edge_no));
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_timeout", 32'(req_ready), 32'd1);
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic amo, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_amo      = amo;
        req_amo_op   = op;
        req_addr     = addr;
        req_wdata    = wd;
        req_valid    = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(rsp_q.size() + wr_q.size()), 32'd0);
        rsp_q.delete();
        wr_q.delete();
    endtask

    // One request; lat is cycles from acceptance to rsp_valid.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic amo, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_err, input int lat,
                          input logic pulse, input logic [31:0] exp_dw, input logic [2:0] exp_ctl);
        wait_ready();
        drive(we, sz, uns, amo, op, addr, wd);
        rsp_q.push_back('{exp_rd, exp_err, edge_cnt + lat});
        if (pulse) begin
            wr_q.push_back('{addr >> 2, exp_dw, exp_ctl, edge_cnt + lat - 1});
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_dmwr"}, 32'(DMWr), 32'd0);
        chk({tag, "_dmcontrol"}, 32'(DmControl), 32'd0);
        chk({tag, "_address"}, Address, 32'd0);
        chk({tag, "_datawr"}, DataWr, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int c;
        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
        mem[3]    = 32'h7F8001FE;
        mem[5]    = 32'h8899AABB;
        mem[8]    = 32'd10;
        mem[1023] = 32'hDEADBEEF;
        rst_n = 1'b0;
        drive(1'b0, SZ_WORD, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        // Loads with sign/zero extension.
        do_req(1'b0, SZ_BYTE, 1'b0, 1'b0, 3'd0, 32'h16, 32'd0, 32'hFFFFFF99, 1'b0, 2, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, SZ_BYTE, 1'b1, 1'b0, 3'd0, 32'h16, 32'd0, 32'h00000099, 1'b0, 2, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 1'b0, 3'd0, 32'h14, 32'd0, 32'h8899AABB, 1'b0, 2, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, SZ_HALF, 1'b0, 1'b0, 3'd0, 32'h0E, 32'd0, 32'h00007F80, 1'b0, 2, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, SZ_BYTE, 1'b0, 1'b0, 3'd0, 32'h0C, 32'd0, 32'hFFFFFFFE, 1'b0, 2, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, SZ_BYTE, 1'b1, 1'b0, 3'd0, 32'h0D, 32'd0, 32'h00000001, 1'b0, 2, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 1'b0, 3'd0, 32'hFFC, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'd0, 3'd0);

        // Back-to-back: req_valid stays high across two loads.
        wait_ready();
        c = edge_cnt;
        drive(1'b0, SZ_BYTE, 1'b0, 1'b0, 3'd0, 32'h17, 32'd0);
        rsp_q.push_back('{32'hFFFFFF88, 1'b0, c + 2});
        rsp_q.push_back('{32'h0000AABB, 1'b0, c + 5});
        @(posedge clk);
        #1 drive(1'b0, SZ_HALF, 1'b1, 1'b0, 3'd0, 32'h14, 32'd0);
        @(negedge clk);
        chk("b2b_ready_read", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_resp", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("b2b_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        drain();

        // Stores and AMO.
        do_req(1'b1, SZ_HALF, 1'b0, 1'b0, 3'd0, 32'h16, 32'h00001234, 32'd0, 1'b0, 4, 1'b1, 32'h1234AABB, DM_WR);
        chk("mem5_after_half", mem[5], 32'h1234AABB);
        do_req(1'b1, SZ_BYTE, 1'b0, 1'b0, 3'd0, 32'h0F, 32'hFFFFFFA5, 32'd0, 1'b0, 4, 1'b1, 32'hA58001FE, DM_WR);
        chk("mem3_after_byte", mem[3], 32'hA58001FE);
        do_req(1'b1, SZ_WORD, 1'b0, 1'b0, 3'd0, 32'h24, 32'h11223344, 32'd0, 1'b0, 3, 1'b1, 32'h11223344, DM_WR);
        chk("mem9_after_word", mem[9], 32'h11223344);
        do_req(1'b1, SZ_WORD, 1'b0, 1'b1, DM_ADD, 32'h20, 32'd5, 32'd10, 1'b0, 4, 1'b1, 32'd5, DM_ADD);
        chk("mem8_after_amo", mem[8], 32'd15);

        // Error requests: one-cycle response, no write strobe.
        do_req(1'b0, SZ_WORD, 1'b0, 1'b0, 3'd0, 32'h03, 32'd0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, SZ_WORD, 1'b0, 1'b0, 3'd0, 32'h1000, 32'd0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 3'd0);
        do_req(1'b1, SZ_HALF, 1'b0, 1'b0, 3'd0, 32'h01, 32'h5555, 32'd0, 1'b1, 1, 1'b0, 32'd0, 3'd0);
        do_req(1'b0, 2'b11, 1'b0, 1'b0, 3'd0, 32'h00, 32'd0, 32'd0, 1'b1, 1, 1'b0, 32'd0, 3'd0);
        do_req(1'b1, SZ_HALF, 1'b0, 1'b1, DM_ADD, 32'h20, 32'd7, 32'd0, 1'b1, 1, 1'b0, 32'd0, 3'd0);
        chk("mem8_after_err", mem[8], 32'd15);

        // Reset while DMWr is high: write already committed, response dropped.
        wait_ready();
        drive(1'b1, SZ_WORD, 1'b0, 1'b0, 3'd0, 32'h40, 32'hCAFEF00D);
        wr_q.push_back('{32'd16, 32'hCAFEF00D, DM_WR, edge_cnt + 2});
        @(posedge clk);
        #1 req_valid = 1'b0;
        t = 0;
        while (!DMWr && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("pulse_seen", 32'(DMWr), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk_idle_outputs("rst_pulse");
        chk("mem16_committed", mem[16], 32'hCAFEF00D);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle_outputs("post_reset");
        chk("queues_empty", 32'(rsp_q.size() + wr_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
